mips_result_checker: RTL
========================

Name: mips_result_checker

Overview:
- Synthesizable self-check stage directly downstream of MIPS_Processor.
- Consumes the processor's exported register taps ($t0, $t1, $s0) and PC.
- Decides pass/fail on-chip so FPGA builds report the result on LEDs without a simulator.
- Replaces end-of-run fixed-delay checking with a stability criterion and a bounded timeout.

Parameters:
- EXP_T0, 32'd20, expected final $t0
- EXP_T1, 32'd15, expected final $t1
- EXP_S0, 32'd1, expected final $s0
- STABLE_CYCLES, 4, consecutive matching samples required for pass (legal range 1..255)
- TIMEOUT, 64, maximum observed cycles before fail (legal range 2..2^CNT_W-1)
- CNT_W, 16, width of cycle counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  start/keep checking; low aborts to IDLE
- pc  in  32  processor PC (captured on termination)
- t0  in  32  processor $t0 tap
- t1  in  32  processor $t1 tap
- s0  in  32  processor $s0 tap
- done  out  1  check finished (PASS or FAIL)
- pass  out  1  all expected values held for STABLE_CYCLES samples
- fail  out  1  timeout reached without pass
- cycle_count  out  CNT_W  observed cycles since start
- mismatch_mask  out  3  {s0,t1,t0} mismatch bits captured at fail
- final_pc  out  32  pc sampled on the terminating edge

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset has priority over all other inputs.
- On reset: state=IDLE; done=pass=fail=0; cycle_count=0; mismatch_mask=0; final_pc=0; stable counter=0.
- match = (t0==EXP_T0)&&(t1==EXP_T1)&&(s0==EXP_S0), sampled at each rising edge. Comparison is combinational and the result is registered; there is no input pipeline.
- States:
  - IDLE: when enable=1 at an edge, go to RUN and clear cycle_count and stable to 0.
  - RUN: at each edge, cycle_count++. If match, go to SETTLE with stable=1. If STABLE_CYCLES==1, go to PASS directly.
  - SETTLE: at each edge, cycle_count++.
    - If match and stable==STABLE_CYCLES-1, go to PASS.
    - Else if match, stable++.
    - Else return to RUN with stable=0.
  - PASS and FAIL are terminal and sticky. Only reset or enable=0 leaves them; both go to IDLE and clear all flags.
- Timeout: at an edge in RUN/SETTLE where cycle_count==TIMEOUT-1 and the pass condition is not met at that same edge, go to FAIL. Exactly TIMEOUT samples are observed.
- Priority inside RUN/SETTLE, highest first:
  1. enable=0, which aborts to IDLE with no flags and leaves cycle_count frozen.
  2. Pass condition.
  3. Timeout.
  A pass and a timeout on the same edge results in PASS.
- On entering PASS: pass=1, done=1, final_pc=pc, mismatch_mask=0.
- On entering FAIL: fail=1, done=1, final_pc=pc, mismatch_mask={s0!=EXP_S0, t1!=EXP_T1, t0!=EXP_T0} from the same edge's inputs.
- cycle_count saturates at all-ones and never wraps. It is frozen in PASS/FAIL/IDLE.
- Outputs are registered; flags appear the cycle after the deciding edge.
- pass and fail are never both 1. done==pass|fail always.
- Reset mid-RUN/SETTLE returns to IDLE on that edge. Checking restarts only after a subsequent enable=1 edge.

Test Plan:
- Defaults; drive t0=20, t1=15, s0=1 from the first edge after enable. Required: pass=1 after the 4th edge in RUN/SETTLE, cycle_count=4, fail=0, done=1.
- Values match for 3 edges, then s0=0 for 1 edge, then match again. Required: return to RUN, stable restarts, pass follows 4 further matching edges, cycle_count=8.
- Defaults; hold t0=20, t1=14, s0=1 forever. Required: fail=1 after 64 edges, cycle_count=64, mismatch_mask=3'b010, final_pc = pc value on the 64th edge.
- TIMEOUT=8; matches begin at edge 5. Required: pass on the 8th edge, because pass wins over timeout; fail=0.
- Drop enable mid-SETTLE (stable=2). Required: IDLE next cycle, all flags 0. Re-raise enable: cycle_count restarts at 0.
- Assert reset in PASS. Required: done=pass=0 and cycle_count=0 the next cycle. STABLE_CYCLES=1 variant: pass after the first matching edge.

Source files
------------

// File: rtl/mips_result_checker.sv
// On-chip pass/fail judge for the MIPS processor: waits for $t0/$t1/$s0 to hold
// their expected values for STABLE_CYCLES samples, or gives up after TIMEOUT samples.
module mips_result_checker #(
  parameter logic [31:0] EXP_T0        = 32'd20,
  parameter logic [31:0] EXP_T1        = 32'd15,
  parameter logic [31:0] EXP_S0        = 32'd1,
  parameter int          STABLE_CYCLES = 4,
  parameter int          TIMEOUT       = 64,
  parameter int          CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [31:0]      pc,
  input  logic [31:0]      t0,
  input  logic [31:0]      t1,
  input  logic [31:0]      s0,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] cycle_count,
  output logic [2:0]       mismatch_mask,
  output logic [31:0]      final_pc
);

  typedef enum logic [2:0] {IDLE, RUN, SETTLE, PASSED, FAILED} state_t;

  state_t           state_reg;
  logic [7:0]       stable_reg;
  logic             match;
  logic [2:0]       miss;
  logic             pass_now;
  logic             at_limit;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    match    = (t0 == EXP_T0) && (t1 == EXP_T1) && (s0 == EXP_S0);
    miss     = {s0 != EXP_S0, t1 != EXP_T1, t0 != EXP_T0};
    at_limit = (cycle_count == CNT_W'(TIMEOUT - 1));
    // From RUN the streak starts at zero, so only a one-sample criterion can finish there.
    pass_now = match && ((state_reg == RUN) ? (STABLE_CYCLES == 1)
                                            : (stable_reg == 8'(STABLE_CYCLES - 1)));
    cnt_next = (&cycle_count) ? cycle_count : cycle_count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      stable_reg    <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      cycle_count   <= '0;
      mismatch_mask <= '0;
      final_pc      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (enable) begin
            state_reg   <= RUN;
            cycle_count <= '0;
            stable_reg  <= '0;
          end
        end
        RUN, SETTLE: begin
          if (!enable) begin
            // Abort keeps cycle_count as-is so the partial run stays visible.
            state_reg <= IDLE;
          end else begin
            cycle_count <= cnt_next;
            if (pass_now) begin
              state_reg     <= PASSED;
              done          <= 1'b1;
              pass          <= 1'b1;
              final_pc      <= pc;
              mismatch_mask <= '0;
            end else if (at_limit) begin
              state_reg     <= FAILED;
              done          <= 1'b1;
              fail          <= 1'b1;
              final_pc      <= pc;
              mismatch_mask <= miss;
            end else if (match) begin
              state_reg  <= SETTLE;
              stable_reg <= (state_reg == RUN) ? 8'd1 : stable_reg + 8'd1;
            end else begin
              state_reg  <= RUN;
              stable_reg <= '0;
            end
          end
        end
        PASSED, FAILED: begin
          if (!enable) begin
            state_reg <= IDLE;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
